// File: rtl/ctrl_pkg.sv
// Shared state encoding, opcode map and control-word layout for the multi-cycle controller.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_t;

    localparam logic [3:0] OP_LOAD     = 4'b0000;
    localparam logic [3:0] OP_STORE    = 4'b0001;
    localparam logic [3:0] OP_JUMP     = 4'b0010;
    localparam logic [3:0] OP_CMP      = 4'b0100;
    localparam logic [3:0] OP_RTYPE    = 4'b1000;
    localparam logic [1:0] OP_IMM_MSB2 = 2'b11;

    localparam logic [6:0] ALUOP_CMP = 7'b1000111;

    typedef struct packed {
        logic mem;
        logic load;
        logic writer;
        logic jump;
        logic set_window;
        logic imm_sel;
        logic illegal;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of the latched instruction into a control word and ALU operation.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W    = 4,
    parameter int unsigned FUNC_W  = 8,
    parameter int unsigned ALUOP_W = 7
) (
    input  logic [OP_W-1:0]    opcode,
    input  logic [FUNC_W-1:0]  func,
    output ctrl_t              cw,
    output logic [ALUOP_W-1:0] aluop
);

    logic [2:0] imm_shamt;

    always_comb begin
        cw        = '0;
        aluop     = '0;
        imm_shamt = {1'b0, opcode[1:0]} + 3'd1;
        // Any opcode bit above the 4-bit decode field makes the instruction illegal
        if ((32'(opcode) >> 4) != 32'd0) begin
            cw.illegal = 1'b1;
        end else begin
            case (opcode[3:0])
                OP_LOAD: begin
                    cw.mem    = 1'b1;
                    cw.load   = 1'b1;
                    cw.writer = 1'b1;
                end
                OP_STORE: cw.mem  = 1'b1;
                OP_JUMP:  cw.jump = 1'b1;
                OP_CMP:   aluop   = ALUOP_W'(ALUOP_CMP);
                OP_RTYPE: begin
                    aluop         = func[ALUOP_W-1:0];
                    cw.set_window = func[7];
                    cw.writer     = (func[7:6] == 2'b00);
                end
                default: begin
                    if (opcode[3:2] == OP_IMM_MSB2) begin
                        aluop      = ALUOP_W'(1) << imm_shamt;
                        cw.imm_sel = 1'b1;
                        cw.writer  = 1'b1;
                    end else begin
                        cw.illegal = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with memory-ack timeout.
// Output registers load the strobes of the state being entered, so each strobe is seen in its own state.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W        = 4,
    parameter int unsigned FUNC_W      = 8,
    parameter int unsigned ALUOP_W     = 7,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FUNC_W-1:0]  func,
    input  logic               mem_ack,
    output logic               setWindow,
    output logic               jump,
    output logic               mem_read,
    output logic               mem_write,
    output logic               immdSel,
    output logic               memOrALU,
    output logic               toWrite,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               illegal,
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t             state;
    logic [OP_W-1:0]    op_q;
    logic [FUNC_W-1:0]  func_q;
    logic [CNT_W-1:0]   tmo_cnt;
    ctrl_t              cw;
    logic [ALUOP_W-1:0] dec_aluop;

    ctrl_decode #(
        .OP_W    (OP_W),
        .FUNC_W  (FUNC_W),
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .opcode (op_q),
        .func   (func_q),
        .cw     (cw),
        .aluop  (dec_aluop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            op_q        <= '0;
            func_q      <= '0;
            tmo_cnt     <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            setWindow   <= 1'b0;
            jump        <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            immdSel     <= 1'b0;
            memOrALU    <= 1'b1;
            toWrite     <= 1'b0;
            ALUop       <= '0;
            illegal     <= 1'b0;
        end else begin
            // Strobes default to idle; each branch raises the ones owned by the next state
            setWindow <= 1'b0;
            jump      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            immdSel   <= 1'b0;
            memOrALU  <= 1'b1;
            toWrite   <= 1'b0;
            ALUop     <= '0;
            illegal   <= 1'b0;

            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        op_q        <= opcode;
                        func_q      <= func;
                        state       <= DECODE;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                DECODE: begin
                    state     <= EXEC;
                    setWindow <= cw.set_window;
                    jump      <= cw.jump;
                    immdSel   <= cw.imm_sel;
                    ALUop     <= dec_aluop;
                    illegal   <= cw.illegal;
                end
                EXEC: begin
                    if (cw.mem) begin
                        state     <= MEM;
                        tmo_cnt   <= '0;
                        mem_read  <= cw.load;
                        mem_write <= ~cw.load;
                    end else if (cw.writer) begin
                        state    <= WB;
                        toWrite  <= 1'b1;
                        memOrALU <= 1'b1;
                        immdSel  <= cw.imm_sel;
                        ALUop    <= dec_aluop;
                    end else begin
                        state       <= FETCH;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                MEM: begin
                    // Ack is checked before the timeout so a same-cycle ack completes normally
                    if (mem_ack) begin
                        if (cw.load) begin
                            state    <= WB;
                            toWrite  <= 1'b1;
                            memOrALU <= 1'b0;
                        end else begin
                            state       <= FETCH;
                            instr_ready <= 1'b1;
                            busy        <= 1'b0;
                        end
                    end else if (tmo_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        state       <= FETCH;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        illegal     <= 1'b1;
                    end else begin
                        tmo_cnt   <= tmo_cnt + CNT_W'(1);
                        mem_read  <= cw.load;
                        mem_write <= ~cw.load;
                    end
                end
                WB: begin
                    state       <= FETCH;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
                default: begin
                    state       <= FETCH;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected output traces checked every cycle.
module tb_multicycle_controller;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] opcode;
    logic [7:0] func;
    logic       mem_ack;
    logic       setWindow, jump, mem_read, mem_write, immdSel, memOrALU, toWrite, illegal, busy;
    logic [6:0] ALUop;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .func        (func),
        .mem_ack     (mem_ack),
        .setWindow   (setWindow),
        .jump        (jump),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .immdSel     (immdSel),
        .memOrALU    (memOrALU),
        .toWrite     (toWrite),
        .ALUop       (ALUop),
        .illegal     (illegal),
        .busy        (busy)
    );

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       setw;
        logic       jump;
        logic       mrd;
        logic       mwr;
        logic       imm;
        logic       moa;
        logic       tow;
        logic [6:0] aluop;
        logic       ill;
    } obs_t;

    obs_t exp_q[$];
    obs_t tmp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic obs_t cur_obs();
        obs_t v;
        v = '{instr_ready, busy, setWindow, jump, mem_read, mem_write,
              immdSel, memOrALU, toWrite, ALUop, illegal};
        return v;
    endfunction

    function automatic obs_t idle_v();
        obs_t v = '0;
        v.ready = 1'b1;
        v.moa   = 1'b1;
        return v;
    endfunction

    function automatic obs_t busy_v();
        obs_t v = '0;
        v.busy = 1'b1;
        v.moa  = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Expected per-cycle outputs from the offering FETCH cycle through the end of the instruction.
    function automatic void build_trace(input logic [3:0] op, input logic [7:0] f, input int ack_at);
        int         o;
        int         n;
        logic       legal, mem, ld, wr, imm, acked;
        logic [6:0] alu;
        obs_t       v;
        o     = int'(op);
        legal = 1'b1;
        mem   = (o < 2);
        ld    = (o == 0);
        wr    = 1'b0;
        imm   = 1'b0;
        alu   = '0;
        case (o)
            0:    wr = 1'b1;
            1, 2: ;
            4:    alu = 7'b1000111;
            8: begin
                alu = f[6:0];
                wr  = (f[7:6] == 2'b00);
            end
            default: begin
                if (o >= 12) begin
                    alu = 7'(2 ** (o - 11));
                    imm = 1'b1;
                    wr  = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
        endcase
        tmp_q.delete();
        tmp_q.push_back(idle_v());
        tmp_q.push_back(busy_v());
        v       = busy_v();
        v.setw  = (o == 8) && f[7];
        v.jump  = (o == 2);
        v.imm   = imm;
        v.aluop = alu;
        v.ill   = ~legal;
        tmp_q.push_back(v);
        acked = (ack_at >= 1) && (ack_at <= TMO);
        if (mem) begin
            n = acked ? ack_at : TMO;
            for (int i = 0; i < n; i++) begin
                v     = busy_v();
                v.mrd = ld;
                v.mwr = ~ld;
                tmp_q.push_back(v);
            end
        end
        if (wr && (!mem || acked)) begin
            v       = busy_v();
            v.tow   = 1'b1;
            v.moa   = ~ld;
            v.imm   = imm;
            v.aluop = alu;
            tmp_q.push_back(v);
        end else if (mem) begin
            v     = idle_v();
            v.ill = ~acked;
            tmp_q.push_back(v);
        end
    endfunction

    always @(negedge clk) begin : compare
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("trace", 32'(cur_obs()), 32'(e));
        end
    end

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected cycles left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [7:0] f, input int ack_at);
        build_trace(op, f, ack_at);
        @(posedge clk);
        #1;
        foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
        instr_valid = 1'b1;
        opcode      = op;
        func        = f;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        opcode      = 4'b0011;
        func        = 8'hff;
        if (ack_at > 0) begin
            repeat (1 + ack_at) @(posedge clk);
            #1;
            mem_ack = 1'b1;
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
        drain();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    initial begin
        obs_t v;
        rst         = 1'b1;
        instr_valid = 1'b1;
        opcode      = 4'b0010;
        func        = 8'h00;
        mem_ack     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(cur_obs()), 32'(idle_v()));
        rst         = 1'b0;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_dropped_transfer", 32'(busy), 32'd0);

        // Pin the model against hand-derived traces
        build_trace(4'b0010, 8'h00, 0);
        chk("model_jump_len", 32'(tmp_q.size()), 32'd3);
        chk("model_jump_strobe", 32'(tmp_q[2].jump), 32'd1);
        build_trace(4'b0001, 8'h00, 0);
        chk("model_store_tmo_len", 32'(tmp_q.size()), 32'd19);
        chk("model_store_tmo_ill", 32'(tmp_q[18].ill), 32'd1);
        build_trace(4'b1101, 8'h00, 0);
        chk("model_imm_aluop", 32'(tmp_q[2].aluop), 32'h04);
        build_trace(4'b0000, 8'h00, 2);
        v = tmp_q[5];
        chk("model_load_wb", 32'({v.tow, v.moa}), 32'b10);

        run(4'b0000, 8'h00, 2);   // LOAD, ack in 2nd MEM cycle
        run(4'b0000, 8'h00, 1);   // LOAD, minimum MEM stay
        run(4'b1000, 8'h05, 0);   // RTYPE with write-back
        run(4'b1000, 8'h85, 0);   // RTYPE window set, no write
        run(4'b1000, 8'h45, 0);   // RTYPE class 01, no write
        run(4'b1101, 8'h00, 0);
        run(4'b1100, 8'h3c, 0);
        run(4'b1111, 8'h00, 0);
        run(4'b0010, 8'h00, 0);   // JUMP
        mem_ack = 1'b1;           // ack outside MEM must be ignored
        run(4'b0100, 8'hff, 0);   // CMP
        mem_ack = 1'b0;
        run(4'b0001, 8'h00, 0);   // STORE timeout
        run(4'b0001, 8'h00, TMO); // ack on the timeout cycle
        run(4'b0001, 8'h00, 3);
        run(4'b0000, 8'h00, 0);   // LOAD timeout, no write-back
        run(4'b0000, 8'h00, TMO);
        run(4'b0011, 8'h00, 0);   // undefined opcodes
        run(4'b0101, 8'h00, 0);
        run(4'b1001, 8'h00, 0);

        // Back-to-back valid: new opcode presented while busy is ignored until FETCH
        build_trace(4'b0010, 8'h00, 0);
        @(posedge clk);
        #1;
        foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
        build_trace(4'b0100, 8'h00, 0);
        foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
        instr_valid = 1'b1;
        opcode      = 4'b0010;
        func        = 8'h00;
        @(posedge clk);
        #1;
        opcode = 4'b0100;
        repeat (3) @(posedge clk);
        #1;
        instr_valid = 1'b0;
        drain();

        // Reset in the middle of a memory wait
        @(posedge clk);
        #1;
        instr_valid = 1'b1;
        opcode      = 4'b0000;
        func        = 8'h00;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midmem_read", 32'(mem_read), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midmem_reset", 32'(cur_obs()), 32'(idle_v()));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_idle", 32'(cur_obs()), 32'(idle_v()));
        run(4'b0001, 8'h00, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
